// File: rtl/vga_timing_gen_pkg.sv
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Default 640x480@60 Hz raster constants, derived totals and
//                sync windows, and the framebuffer address helper shared by
//                the VGA timing generator and its interface.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  // Horizontal timing, in pixels
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;

  // Vertical timing, in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  // Derived totals and sync windows (inclusive bounds)
  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Framebuffer window anchored at the top-left of the screen
  localparam int IMG_W      = 256;
  localparam int IMG_H      = 256;
  localparam int IMG_W_LOG2 = $clog2(IMG_W);

  // Latency of the downstream colour stage
  localparam int PIPE_DLY = 1;

  // Datapath widths
  localparam int CNT_W  = 10;
  localparam int ADDR_W = 16;

  // Signals that travel through the delay line alongside the colour read
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic in_image;
  } dly_bundle_t;

  // Syncs idle high, enables idle low
  localparam dly_bundle_t DLY_RST_VAL = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, in_image: 1'b0};

  // Framebuffer address as a shift-or; valid because x < IMG_W inside the window
  function automatic logic [ADDR_W-1:0] pixel_addr(
    input logic [CNT_W-1:0] x,
    input logic [CNT_W-1:0] y,
    input int               w_log2
  );
    logic [ADDR_W-1:0] w_y_ext;
    logic [ADDR_W-1:0] w_x_ext;
    w_y_ext = {{(ADDR_W-CNT_W){1'b0}}, y};
    w_x_ext = {{(ADDR_W-CNT_W){1'b0}}, x};
    return (w_y_ext << w_log2) | w_x_ext;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
// ============================================================================
//  Module      : vga_timing_gen_if
//  Description : Raster bundle between the timing generator (master) and the
//                colour/framebuffer stage and DAC pins (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [CNT_W-1:0]  x_pos;
  logic [CNT_W-1:0]  y_pos;
  logic              display_enable;
  logic [ADDR_W-1:0] addr_out;
  logic              in_image;
  logic              frame_start;
  logic              hsync_d;
  logic              vsync_d;
  logic              de_d;
  logic              in_image_d;

  modport master (
    output x_pos, y_pos, display_enable, addr_out, in_image, frame_start,
    output hsync_d, vsync_d, de_d, in_image_d
  );

  modport slave (
    input x_pos, y_pos, display_enable, addr_out, in_image, frame_start,
    input hsync_d, vsync_d, de_d, in_image_d
  );

endinterface

`default_nettype wire

// File: rtl/vga_timing_gen_delay_line.sv
// ============================================================================
//  Module      : vga_delay_line
//  Description : Parameterised-width, parameterised-depth shift register with
//                asynchronous active-low reset to a per-bit reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_delay_line #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per clock; every stage returns to RST_VAL on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing generator. Free-running h/v counters feed
//                registered position, enable, framebuffer address and sync;
//                syncs and enables are further delayed PIPE_DLY cycles to
//                line up with the colour stage's registered memory read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int IMG_W    = vga_timing_pkg::IMG_W,
  parameter int IMG_H    = vga_timing_pkg::IMG_H,
  parameter int PIPE_DLY = vga_timing_pkg::PIPE_DLY
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga_o
);

  // Window compares use a width that holds IMG_W/IMG_H up to 65536
  localparam int c_ext_w = 17;

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] c_h_last   = CNT_W'(c_h_total - 1);
  localparam logic [CNT_W-1:0] c_v_last   = CNT_W'(c_v_total - 1);
  localparam logic [CNT_W-1:0] c_h_active = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_v_active = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_hs_start = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] c_hs_end   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] c_vs_start = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] c_vs_end   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [c_ext_w-1:0] c_img_w = c_ext_w'(IMG_W);
  localparam logic [c_ext_w-1:0] c_img_h = c_ext_w'(IMG_H);
  localparam int                 c_img_w_log2 = $clog2(IMG_W);

  // Raster counters
  logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;

  // Registered per-pixel outputs
  logic [CNT_W-1:0]  x_pos_q, x_pos_d;
  logic [CNT_W-1:0]  y_pos_q, y_pos_d;
  logic              de_q, de_d;
  logic              in_image_q, in_image_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              frame_start_q, frame_start_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;

  // Combinational decode of the current counter position
  logic              w_h_wrap;
  logic              w_active;
  logic              w_in_img;
  logic [c_ext_w-1:0] w_h_ext;
  logic [c_ext_w-1:0] w_v_ext;

  dly_bundle_t       w_dly_in;
  dly_bundle_t       w_dly_out;

  // Counter advance and decode of the pixel the counters currently point at
  always_comb begin
    w_h_wrap = (h_cnt_q == c_h_last);
    h_cnt_d  = w_h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d  = v_cnt_q;
    if (w_h_wrap) begin
      v_cnt_d = (v_cnt_q == c_v_last) ? '0 : v_cnt_q + 1'b1;
    end

    w_h_ext  = {{(c_ext_w-CNT_W){1'b0}}, h_cnt_q};
    w_v_ext  = {{(c_ext_w-CNT_W){1'b0}}, v_cnt_q};
    w_active = (h_cnt_q < c_h_active) && (v_cnt_q < c_v_active);
    w_in_img = w_active && (w_h_ext < c_img_w) && (w_v_ext < c_img_h);

    x_pos_d       = w_active ? h_cnt_q : '0;
    y_pos_d       = w_active ? v_cnt_q : '0;
    de_d          = w_active;
    in_image_d    = w_in_img;
    addr_d        = w_in_img ? pixel_addr(h_cnt_q, v_cnt_q, c_img_w_log2) : '0;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    hs_d          = !((h_cnt_q >= c_hs_start) && (h_cnt_q <= c_hs_end));
    vs_d          = !((v_cnt_q >= c_vs_start) && (v_cnt_q <= c_vs_end));
  end

  // Counter and output registers; reset clears everything to an idle raster
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_pos_q       <= '0;
      y_pos_q       <= '0;
      de_q          <= 1'b0;
      in_image_q    <= 1'b0;
      addr_q        <= '0;
      frame_start_q <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_pos_q       <= x_pos_d;
      y_pos_q       <= y_pos_d;
      de_q          <= de_d;
      in_image_q    <= in_image_d;
      addr_q        <= addr_d;
      frame_start_q <= frame_start_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  // Syncs and enables follow the colour stage's read latency
  assign w_dly_in = '{hsync: hs_q, vsync: vs_q, de: de_q, in_image: in_image_q};

  vga_delay_line #(
    .WIDTH   ($bits(dly_bundle_t)),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (DLY_RST_VAL)
  ) u_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (w_dly_in),
    .data_o (w_dly_out)
  );

  assign vga_o.x_pos          = x_pos_q;
  assign vga_o.y_pos          = y_pos_q;
  assign vga_o.display_enable = de_q;
  assign vga_o.addr_out       = addr_q;
  assign vga_o.in_image       = in_image_q;
  assign vga_o.frame_start    = frame_start_q;
  assign vga_o.hsync_d        = w_dly_out.hsync;
  assign vga_o.vsync_d        = w_dly_out.vsync;
  assign vga_o.de_d           = w_dly_out.de;
  assign vga_o.in_image_d     = w_dly_out.in_image;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench. DUT A uses the default 640x480 timing
//                with PIPE_DLY=1; DUT B uses a reduced raster (56x37 total,
//                16x16 image) with PIPE_DLY=3 so full frames fit quickly.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing_gen;

  localparam int B_HACT = 40, B_HFP = 4, B_HSYNC = 8, B_HBP = 4;
  localparam int B_VACT = 30, B_VFP = 2, B_VSYNC = 2, B_VBP = 3;
  localparam int B_IMGW = 16, B_IMGH = 16, B_DLY = 3;
  localparam int N_VEC  = 11;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic        img;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [15:0] addr;
  } pix_t;

  typedef struct {
    int          k;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic        img;
    logic [15:0] addr;
    logic        fs;
    logic        de_d;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if if_a();
  vga_timing_gen_if if_b();

  vga_timing_gen u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .vga_o (if_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (B_HACT), .H_FP (B_HFP), .H_SYNC (B_HSYNC), .H_BP (B_HBP),
    .V_ACTIVE (B_VACT), .V_FP (B_VFP), .V_SYNC (B_VSYNC), .V_BP (B_VBP),
    .IMG_W    (B_IMGW), .IMG_H (B_IMGH), .PIPE_DLY (B_DLY)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .vga_o (if_b)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_k    = 0;
  vec_t vecs [N_VEC];

  int a_hs_first, a_hs_low, a_de_high, b_vs_low, b_fs_first, b_fs_second;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)", name, act, exp, cur_k, $time);
    end
  endtask

  // Reference raster: pixel index p since (0,0), addresses via multiply
  function automatic pix_t model(input int p, input int hact, input int hfp, input int hsync,
                                 input int hbp, input int vact, input int vfp, input int vsync,
                                 input int vbp, input int imgw, input int imgh);
    pix_t r;
    int htot, vtot, h, v;
    logic act;
    htot   = hact + hfp + hsync + hbp;
    vtot   = vact + vfp + vsync + vbp;
    h      = p % htot;
    v      = (p / htot) % vtot;
    act    = (h < hact) && (v < vact);
    r.x    = act ? 10'(h) : 10'd0;
    r.y    = act ? 10'(v) : 10'd0;
    r.de   = act;
    r.img  = act && (h < imgw) && (v < imgh);
    r.addr = r.img ? 16'(v * imgw + h) : 16'd0;
    r.fs   = (h == 0) && (v == 0);
    r.hs   = !((h >= hact + hfp) && (h < hact + hfp + hsync));
    r.vs   = !((v >= vact + vfp) && (v < vact + vfp + vsync));
    return r;
  endfunction

  function automatic pix_t reset_pix();
    pix_t r;
    r.x = '0; r.y = '0; r.de = 1'b0; r.img = 1'b0; r.fs = 1'b0;
    r.hs = 1'b1; r.vs = 1'b1; r.addr = '0;
    return r;
  endfunction

  task automatic check_outputs(input string tag,
                               input logic [9:0] x, input logic [9:0] y, input logic de,
                               input logic img, input logic [15:0] addr, input logic fs,
                               input logic hsd, input logic vsd, input logic ded, input logic imgd,
                               input pix_t cur, input pix_t del);
    check({tag, ".x_pos"},          32'(x),    32'(cur.x));
    check({tag, ".y_pos"},          32'(y),    32'(cur.y));
    check({tag, ".display_enable"}, 32'(de),   32'(cur.de));
    check({tag, ".in_image"},       32'(img),  32'(cur.img));
    check({tag, ".addr_out"},       32'(addr), 32'(cur.addr));
    check({tag, ".frame_start"},    32'(fs),   32'(cur.fs));
    check({tag, ".hsync_d"},        32'(hsd),  32'(del.hs));
    check({tag, ".vsync_d"},        32'(vsd),  32'(del.vs));
    check({tag, ".de_d"},           32'(ded),  32'(del.de));
    check({tag, ".in_image_d"},     32'(imgd), 32'(del.img));
  endtask

  task automatic check_both_reset(input string tag);
    check_outputs({tag, "_a"}, if_a.x_pos, if_a.y_pos, if_a.display_enable, if_a.in_image,
                  if_a.addr_out, if_a.frame_start, if_a.hsync_d, if_a.vsync_d, if_a.de_d,
                  if_a.in_image_d, reset_pix(), reset_pix());
    check_outputs({tag, "_b"}, if_b.x_pos, if_b.y_pos, if_b.display_enable, if_b.in_image,
                  if_b.addr_out, if_b.frame_start, if_b.hsync_d, if_b.vsync_d, if_b.de_d,
                  if_b.in_image_d, reset_pix(), reset_pix());
  endtask

  // Runs n clocks after a reset release; edge k shows pixel k-1
  task automatic run_phase(input int n);
    int   ti;
    pix_t cur, del;
    ti = 0;
    a_hs_first = -1; a_hs_low = 0; a_de_high = 0;
    b_vs_low = 0; b_fs_first = -1; b_fs_second = -1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      cur_k = k;

      cur = model(k - 1, 640, 16, 96, 48, 480, 10, 2, 33, 256, 256);
      del = (k - 2 < 0) ? reset_pix() : model(k - 2, 640, 16, 96, 48, 480, 10, 2, 33, 256, 256);
      check_outputs("a", if_a.x_pos, if_a.y_pos, if_a.display_enable, if_a.in_image,
                    if_a.addr_out, if_a.frame_start, if_a.hsync_d, if_a.vsync_d, if_a.de_d,
                    if_a.in_image_d, cur, del);

      cur = model(k - 1, B_HACT, B_HFP, B_HSYNC, B_HBP, B_VACT, B_VFP, B_VSYNC, B_VBP, B_IMGW, B_IMGH);
      del = (k - 1 - B_DLY < 0) ? reset_pix() :
            model(k - 1 - B_DLY, B_HACT, B_HFP, B_HSYNC, B_HBP, B_VACT, B_VFP, B_VSYNC, B_VBP, B_IMGW, B_IMGH);
      check_outputs("b", if_b.x_pos, if_b.y_pos, if_b.display_enable, if_b.in_image,
                    if_b.addr_out, if_b.frame_start, if_b.hsync_d, if_b.vsync_d, if_b.de_d,
                    if_b.in_image_d, cur, del);

      if (ti < N_VEC && vecs[ti].k == k) begin
        check("vec.x_pos",          32'(if_a.x_pos),          32'(vecs[ti].x));
        check("vec.y_pos",          32'(if_a.y_pos),          32'(vecs[ti].y));
        check("vec.display_enable", 32'(if_a.display_enable), 32'(vecs[ti].de));
        check("vec.in_image",       32'(if_a.in_image),       32'(vecs[ti].img));
        check("vec.addr_out",       32'(if_a.addr_out),       32'(vecs[ti].addr));
        check("vec.frame_start",    32'(if_a.frame_start),    32'(vecs[ti].fs));
        check("vec.de_d",           32'(if_a.de_d),           32'(vecs[ti].de_d));
        ti++;
      end

      if (k == 841) check("b_addr_0_15",  32'(if_b.addr_out), 32'h00F0);
      if (k == 856) check("b_addr_15_15", 32'(if_b.addr_out), 32'h00FF);

      if (k <= 800) begin
        if (!if_a.hsync_d) begin
          a_hs_low++;
          if (a_hs_first < 0) a_hs_first = k;
        end
        if (if_a.display_enable) a_de_high++;
      end
      if (!if_b.vsync_d) b_vs_low++;
      if (if_b.frame_start) begin
        if (b_fs_first < 0) b_fs_first = k;
        else if (b_fs_second < 0) b_fs_second = k;
      end
    end
  endtask

  initial begin
    //            k     x       y      de    img   addr      fs    de_d
    vecs[0]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{2,    10'd1,   10'd0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1};
    vecs[2]  = '{256,  10'd255, 10'd0, 1'b1, 1'b1, 16'h00FF, 1'b0, 1'b1};
    vecs[3]  = '{257,  10'd256, 10'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[4]  = '{640,  10'd639, 10'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[5]  = '{641,  10'd0,   10'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[6]  = '{800,  10'd0,   10'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{801,  10'd0,   10'd1, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0};
    vecs[8]  = '{1056, 10'd255, 10'd1, 1'b1, 1'b1, 16'h01FF, 1'b0, 1'b1};
    vecs[9]  = '{1057, 10'd256, 10'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{1701, 10'd100, 10'd2, 1'b1, 1'b1, 16'h0264, 1'b0, 1'b1};

    // Held in reset across several clocks
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_both_reset("reset");

    // First run, long enough for a full frame of DUT B plus part of the next
    @(negedge clk);
    rst_n = 1'b1;
    run_phase(3223);
    check("a_hsync_fall_cycle", 32'(a_hs_first), 32'd658);
    check("a_hsync_low_cycles", 32'(a_hs_low),   32'd96);
    check("a_de_high_line0",    32'(a_de_high),  32'd640);
    check("b_vsync_low_cycles", 32'(b_vs_low),   32'd112);
    check("b_frame_first",      32'(b_fs_first), 32'd1);
    check("b_frame_period",     32'(b_fs_second - b_fs_first), 32'd2072);

    // Mid-frame reset between clock edges; outputs must clear without a clock
    #2;
    rst_n = 1'b0;
    #1;
    check_both_reset("async_reset");
    repeat (3) @(posedge clk);
    #1;
    check_both_reset("held_reset");

    // After release the raster restarts exactly as after the first reset
    @(negedge clk);
    rst_n = 1'b1;
    run_phase(1200);
    check("a_hsync_fall_cycle_2", 32'(a_hs_first), 32'd658);
    check("a_hsync_low_cycles_2", 32'(a_hs_low),   32'd96);
    check("a_de_high_line0_2",    32'(a_de_high),  32'd640);
    check("b_frame_first_2",      32'(b_fs_first), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
